// File: rtl/sdram_cmd_pkg.sv
// Shared command codes and sequencer state encoding for the UART-to-SDRAM command path.
package sdram_cmd_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_READ  = 8'h72;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    ISSUE    = 3'd3,
    WAIT_RD  = 3'd4,
    SEND     = 3'd5
  } seq_state_t;

  function automatic logic is_busy(input seq_state_t s);
    return (s == ISSUE) || (s == WAIT_RD) || (s == SEND);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired_o flags the last enabled cycle of a Cycles-long window.
module cycle_timer #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(Cycles + 1);

  logic [W-1:0] count_q, count_d;

  // Next count: reload wins over counting down
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = W'(Cycles);
    end else if (en_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(32'd1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && !load_i && (count_q == W'(32'd1));

endmodule

// File: rtl/uart_sdram_cmd_sequencer.sv
// Parses 'w' addr data / 'r' addr byte commands from the UART, issues one SDRAM
// request per command and returns the low read byte; timeouts keep the link alive.
module uart_sdram_cmd_sequencer
  import sdram_cmd_pkg::*;
#(
  parameter int unsigned ClockFreq        = 133_000_000,
  parameter int unsigned AddrWidth        = 24,
  parameter int unsigned DataWidth        = 16,
  parameter int unsigned ReqTimeoutCycles = 4096
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_data,
  output logic                 o_tx_valid,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_ready,
  output logic                 o_req,
  output logic                 o_req_we,
  output logic [AddrWidth-1:0] o_req_addr,
  output logic [DataWidth-1:0] o_req_wdata,
  input  logic                 i_req_ack,
  input  logic                 i_rd_valid,
  input  logic [DataWidth-1:0] i_rd_data,
  output logic                 o_busy,
  output logic                 o_err_timeout
);

  localparam int unsigned ByteTimeoutCycles = ClockFreq / 32'd1000;

  seq_state_t           state_q, state_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 req_q, req_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic byte_load_s, byte_en_s, byte_exp_s;
  logic req_load_s, req_en_s, req_exp_s;
  logic unused_s;

  assign byte_en_s = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign req_en_s  = (state_q == ISSUE) || (state_q == WAIT_RD);
  assign unused_s  = ^i_rd_data[DataWidth-1:8];

  cycle_timer #(.Cycles(ByteTimeoutCycles)) u_byte_timer (
    .clk_i    (i_sys_clk),
    .rst_i    (i_rst),
    .load_i   (byte_load_s),
    .en_i     (byte_en_s),
    .expired_o(byte_exp_s)
  );

  cycle_timer #(.Cycles(ReqTimeoutCycles)) u_req_timer (
    .clk_i    (i_sys_clk),
    .rst_i    (i_rst),
    .load_i   (req_load_s),
    .en_i     (req_en_s),
    .expired_o(req_exp_s)
  );

  // Next-state and output decode; progress (byte, ack, data) beats a same-cycle timeout
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_data_d   = tx_data_q;
    req_d       = req_q;
    tx_valid_d  = tx_valid_q;
    err_d       = 1'b0;
    byte_load_s = 1'b0;
    req_load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rx_valid && (i_rx_data == CMD_WRITE)) begin
          state_d = GET_ADDR; we_d = 1'b1; byte_load_s = 1'b1;
        end else if (i_rx_valid && (i_rx_data == CMD_READ)) begin
          state_d = GET_ADDR; we_d = 1'b0; byte_load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GET_ADDR: begin
        if (i_rx_valid) begin
          addr_d = AddrWidth'(i_rx_data);
          if (we_q) begin
            state_d = GET_DATA; byte_load_s = 1'b1;
          end else begin
            state_d = ISSUE; req_d = 1'b1; req_load_s = 1'b1;
          end
        end else if (byte_exp_s) begin
          state_d = IDLE; err_d = 1'b1;
        end else begin
          state_d = GET_ADDR;
        end
      end
      GET_DATA: begin
        if (i_rx_valid) begin
          wdata_d = DataWidth'(i_rx_data);
          state_d = ISSUE; req_d = 1'b1; req_load_s = 1'b1;
        end else if (byte_exp_s) begin
          state_d = IDLE; err_d = 1'b1;
        end else begin
          state_d = GET_DATA;
        end
      end
      ISSUE: begin
        if (i_req_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = IDLE;
          end else if (i_rd_valid) begin
            tx_data_d = i_rd_data[7:0]; tx_valid_d = 1'b1; state_d = SEND;
          end else begin
            state_d = WAIT_RD;
          end
        end else if (req_exp_s) begin
          req_d = 1'b0; state_d = IDLE; err_d = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RD: begin
        if (i_rd_valid) begin
          tx_data_d = i_rd_data[7:0]; tx_valid_d = 1'b1; state_d = SEND;
        end else if (req_exp_s) begin
          state_d = IDLE; err_d = 1'b1;
        end else begin
          state_d = WAIT_RD;
        end
      end
      SEND: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0; state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE; req_d = 1'b0; tx_valid_d = 1'b0;
      end
    endcase
    busy_d = is_busy(state_d);
  end

  // State and registered outputs
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= {AddrWidth{1'b0}};
      wdata_q    <= {DataWidth{1'b0}};
      tx_data_q  <= 8'h00;
      req_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      req_q      <= req_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_req         = req_q;
  assign o_req_we      = we_q & req_q;
  assign o_req_addr    = addr_q;
  assign o_req_wdata   = wdata_q;
  assign o_tx_valid    = tx_valid_q;
  assign o_tx_data     = tx_data_q;
  assign o_busy        = busy_q;
  assign o_err_timeout = err_q;

endmodule
